// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: one outstanding data-memory access with a held response
// Non-memory results pass straight through to the response; loads/stores drive a single-port word memory.
module lsu #(
    parameter int DW = 32,
    parameter int IW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [IW-1:0] inst,
    input  logic [DW-1:0] addr,
    input  logic [DW-1:0] store_data,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [DW-1:0] resp_data,
    output logic          resp_err,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [3:0]    dmem_be,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata
);

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    logic [4:0]    opcode;
    logic [2:0]    funct3;
    logic          is_load;
    logic          is_store;
    logic          f3_legal;
    logic          aligned;
    logic          mem_ok;
    logic          mem_bad;
    logic          accept;
    logic [3:0]    be_nxt;
    logic [DW-1:0] wdata_nxt;

    logic [2:0]    f3_q;
    logic          store_q;
    logic [1:0]    lane_q;
    logic [3:0]    be_q;
    logic [DW-1:0] dmem_addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] resp_data_q;
    logic          resp_err_q;

    logic [DW-1:0] rdata_sh;
    logic [DW-1:0] load_data;

    // Only opcode and funct3 matter here; the remaining instruction bits are deliberately ignored.
    logic unused_inst;
    assign unused_inst = ^{inst[IW-1:15], inst[11:7], inst[1:0]};

    assign opcode   = inst[6:2];
    assign funct3   = inst[14:12];
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign accept   = req_valid && (state == S_IDLE);
    assign mem_ok   = (is_load || is_store) && f3_legal && aligned;
    assign mem_bad  = (is_load || is_store) && !(f3_legal && aligned);

    always_comb begin
        f3_legal  = 1'b0;
        aligned   = 1'b1;
        be_nxt    = 4'b1111;
        wdata_nxt = store_data;
        if (is_load) begin
            f3_legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end else if (is_store) begin
            f3_legal = funct3 inside {3'b000, 3'b001, 3'b010};
        end
        case (funct3[1:0])
            2'b00: begin
                be_nxt    = 4'b0001 << addr[1:0];
                wdata_nxt = {(DW/8){store_data[7:0]}};
            end
            2'b01: begin
                aligned   = ~addr[0];
                be_nxt    = 4'b0011 << addr[1:0];
                wdata_nxt = {(DW/16){store_data[15:0]}};
            end
            2'b10: begin
                aligned   = (addr[1:0] == 2'b00);
            end
            default: begin
                aligned   = 1'b1;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0 before sizing/extending.
    always_comb begin
        rdata_sh  = dmem_rdata >> {lane_q, 3'b000};
        load_data = rdata_sh;
        case (f3_q)
            3'b000:  load_data = {{(DW-8){rdata_sh[7]}}, rdata_sh[7:0]};
            3'b001:  load_data = {{(DW-16){rdata_sh[15]}}, rdata_sh[15:0]};
            3'b100:  load_data = {{(DW-8){1'b0}}, rdata_sh[7:0]};
            3'b101:  load_data = {{(DW-16){1'b0}}, rdata_sh[15:0]};
            default: load_data = rdata_sh;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = mem_ok ? S_MEM : S_RESP;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_q        <= 3'b000;
            store_q     <= 1'b0;
            lane_q      <= 2'b00;
            be_q        <= 4'b0000;
            dmem_addr_q <= '0;
            wdata_q     <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else if (accept) begin
            if (mem_ok) begin
                f3_q        <= funct3;
                store_q     <= is_store;
                lane_q      <= addr[1:0];
                be_q        <= be_nxt;
                dmem_addr_q <= {addr[DW-1:2], 2'b00};
                wdata_q     <= wdata_nxt;
            end else begin
                resp_data_q <= mem_bad ? '0 : addr;
                resp_err_q  <= mem_bad;
            end
        end else if ((state == S_MEM) && dmem_ack) begin
            resp_data_q <= store_q ? '0 : load_data;
            resp_err_q  <= 1'b0;
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign dmem_req   = (state == S_MEM);
    assign dmem_we    = dmem_req && store_q;
    assign dmem_be    = dmem_req ? be_q : 4'b0000;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = wdata_q;

endmodule
